// File: rtl/deser8.sv
// deser8: collects a serial bit stream into 8-bit words on a valid/ready port, with OR-reduce flag.
// Optional even-parity framing (9th bit) is enabled by defining DESER8_PARITY_EN.
module deser8 #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_any,
    output logic       out_perr,
    output logic       out_valid,
    input  logic       out_ready
);

`ifdef DESER8_PARITY_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif

    logic [7:0] sr;
    logic [3:0] cnt;
    logic       full;
    logic       held_perr;
    logic       perr_q;
    logic       accept;
    logic       slot_free;
    logic       frame_done;
    logic [7:0] word;
    logic       word_perr;

    assign in_ready   = !full;
    assign accept     = in_valid && in_ready;
    assign slot_free  = !out_valid || out_ready;
    assign frame_done = accept && (cnt == LAST);
    assign out_perr   = perr_q;

    // Word as it would look with the current bit merged in; the parity bit (cnt==8) is not stored.
    always_comb begin
        word = sr;
        if (cnt < 4'd8) begin
            if (LSB_FIRST != 0)
                word[cnt[2:0]] = in_bit;
            else
                word[3'd7 - cnt[2:0]] = in_bit;
        end
    end

`ifdef DESER8_PARITY_EN
    assign word_perr = ^{sr, in_bit};
`else
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            full      <= 1'b0;
            held_perr <= 1'b0;
            out_data  <= '0;
            out_any   <= 1'b0;
            perr_q    <= 1'b0;
            out_valid <= 1'b0;
        end else if (full) begin
            // No input is accepted while full; wait for the consumer to take the current word.
            if (out_valid && out_ready) begin
                out_data  <= sr;
                out_any   <= |sr;
                perr_q    <= held_perr;
                out_valid <= 1'b1;
                full      <= 1'b0;
                cnt       <= '0;
                sr        <= '0;
            end
        end else if (frame_done) begin
            if (slot_free) begin
                out_data  <= word;
                out_any   <= |word;
                perr_q    <= word_perr;
                out_valid <= 1'b1;
                cnt       <= '0;
                sr        <= '0;
            end else begin
                sr        <= word;
                held_perr <= word_perr;
                full      <= 1'b1;
            end
        end else begin
            if (accept) begin
                sr  <= word;
                cnt <= cnt + 4'd1;
            end
            if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deser8.sv
// Directed self-checking bench for deser8: reset, back-to-back, backpressure, mid-frame reset,
// MSB-first ordering with gaps, and parity framing when DESER8_PARITY_EN is defined.
module tb_deser8;

`ifdef DESER8_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_any, out_perr, out_valid;
    logic [7:0] out_data;
    logic       m_in_bit = 1'b0, m_in_valid = 1'b0, m_out_ready = 1'b1;
    logic       m_in_ready, m_out_any, m_out_perr, m_out_valid;
    logic [7:0] m_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deser8 #(.LSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_any(out_any), .out_perr(out_perr), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    deser8 #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_bit(m_in_bit), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_data(m_out_data), .out_any(m_out_any), .out_perr(m_out_perr), .out_valid(m_out_valid),
        .out_ready(m_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame bits for a data byte, LSB first, with an even-parity bit appended when enabled.
    function automatic logic [8:0] frame_of(input logic [7:0] d, input logic par);
        return {par, d};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
        checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", out_any); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", out_perr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [8:0] f;
        logic       rdy_low;
        f = frame_of(8'h19, 1'b1);
        out_ready = 1'b1;
        rdy_low = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            in_valid = 1'b1; in_bit = f[i];
            if (in_ready !== 1'b1) rdy_low = 1'b1;
            step();
            if (i < FRAME - 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid bit %0d got %b exp 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'h19) begin errors++; $display("FAIL basic_data got %h exp 19", out_data); end
        checks++; if (out_any !== 1'b1) begin errors++; $display("FAIL basic_any got %b exp 1", out_any); end
        checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL basic_perr got %b exp 0", out_perr); end
        checks++; if (rdy_low !== 1'b0) begin errors++; $display("FAIL basic_in_ready_dropped got %b exp 0", rdy_low); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] f [2];
        logic       rdy_low;
        f[0] = frame_of(8'h00, 1'b0);
        f[1] = frame_of(8'h20, 1'b1);
        out_ready = 1'b1;
        rdy_low = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < FRAME; i++) begin
                in_valid = 1'b1; in_bit = f[w][i];
                if (in_ready !== 1'b1) rdy_low = 1'b1;
                step();
                if (i == FRAME - 1 && w == 0) begin
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %b exp 1", out_valid); end
                    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h exp 00", out_data); end
                    checks++; if (out_any !== 1'b0) begin errors++; $display("FAIL b2b_any0 got %b exp 0", out_any); end
                end
                if (i == 2 && w == 1) begin
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_mid_valid got %b exp 0", out_valid); end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'h20) begin errors++; $display("FAIL b2b_data1 got %h exp 20", out_data); end
        checks++; if (out_any !== 1'b1) begin errors++; $display("FAIL b2b_any1 got %b exp 1", out_any); end
        checks++; if (rdy_low !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_dropped got %b exp 0", rdy_low); end
        step();
    endtask

    task automatic test_backpressure();
        logic [8:0] f [2];
        logic       rdy_low;
        f[0] = frame_of(8'h54, 1'b1);
        f[1] = frame_of(8'h55, 1'b0);
        out_ready = 1'b0;
        rdy_low = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < FRAME; i++) begin
                in_valid = 1'b1; in_bit = f[w][i];
                if (in_ready !== 1'b1) rdy_low = 1'b1;
                step();
            end
        end
        in_valid = 1'b0;
        checks++; if (rdy_low !== 1'b0) begin errors++; $display("FAIL bp_accept_dropped got %b exp 0", rdy_low); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b exp 0", in_ready); end
        checks++; if (out_data !== 8'h54) begin errors++; $display("FAIL bp_held_data got %h exp 54", out_data); end
        step();
        checks++; if (out_data !== 8'h54 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got %h/%b exp 54/1", out_data, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stall got %b exp 0", in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL bp_next_data got %h exp 55", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b exp 1", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %b exp 1", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] f;
        out_ready = 1'b0;
        f = frame_of(8'hff, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            in_valid = 1'b1; in_bit = f[i]; step();
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = 1'b1; step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        f = frame_of(8'h01, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            in_valid = 1'b1; in_bit = f[i]; step();
            if (i < FRAME - 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early bit %0d got %b exp 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL rstmid_word got %h/%b exp 01/1", out_data, out_valid); end
        step();
    endtask

    task automatic test_bit_order();
        logic [8:0] f;
        f = 9'b1_0000_0001;  // bits in send order: 1,0,0,0,0,0,0,0 then parity 1
        m_out_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            m_in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            m_in_valid = 1'b1; m_in_bit = f[i]; step();
            m_in_valid = 1'b0;
            if (i < FRAME - 1) begin
                checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL order_early bit %0d got %b exp 0", i, m_out_valid); end
            end
        end
        checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL order_valid got %b exp 1", m_out_valid); end
        checks++; if (m_out_data !== 8'h80) begin errors++; $display("FAIL order_data got %h exp 80", m_out_data); end
        checks++; if (m_out_any !== 1'b1) begin errors++; $display("FAIL order_any got %b exp 1", m_out_any); end
        step();
    endtask

`ifdef DESER8_PARITY_EN
    task automatic test_parity();
        logic [8:0] f;
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            f = frame_of(8'h19, (p == 0) ? 1'b1 : 1'b0);
            for (int i = 0; i < FRAME; i++) begin
                in_valid = 1'b1; in_bit = f[i]; step();
            end
            in_valid = 1'b0;
            checks++; if (out_data !== 8'h19) begin errors++; $display("FAIL parity_data%0d got %h exp 19", p, out_data); end
            checks++; if (out_perr !== (p == 1)) begin errors++; $display("FAIL parity_perr%0d got %b exp %b", p, out_perr, (p == 1)); end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_bit_order();
`ifdef DESER8_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
